spi_slave_regif: RTL and testbench

- SPI slave (target) end of the 3-byte SPI frame produced by the team's SPI master: command byte, address byte, then one data byte (MOSI write or MISO read).
- Oversamples SCLK/CSN/MOSI in the system clock domain and turns each frame into a single-cycle register-file write strobe or a read request with fixed 1-cycle read latency.
- Sits in front of the local register bank on the slave side of the spi2axi path.
- SPI mode 0: SCLK idles low, MSB first, master shifts on falling edge and samples on rising edge.

---
 rtl/spi_slave_pkg.sv | 28 ++
 rtl/spi_slave_regif_sync.sv | 31 +++
 rtl/spi_slave_regif.sv | 200 ++++++++++++++++++++
 tb/tb_spi_slave_regif.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI slave register interface.
package spi_slave_pkg;

    // One-hot frame states
    typedef enum logic [5:0] {
        ST_IDLE     = 6'b000001,
        ST_CMD      = 6'b000010,
        ST_ADDR     = 6'b000100,
        ST_WDATA    = 6'b001000,
        ST_RDATA    = 6'b010000,
        ST_WAIT_CSN = 6'b100000
    } state_t;

    localparam logic [7:0] CMD_WR_DEF = 8'h02;
    localparam logic [7:0] CMD_RD_DEF = 8'h03;

    // Shortest SCLK half-period (in sclk cycles) the oversampler can follow
    localparam int MIN_HALF_PERIOD = 4;

    // Fewest flops allowed in an input synchronizer
    localparam int SYNC_MIN = 2;

    // States in which a CSN rise means the master gave up mid-frame
    function automatic logic in_frame(input state_t s);
        return (s == ST_CMD) || (s == ST_ADDR) || (s == ST_WDATA) || (s == ST_RDATA);
    endfunction

endpackage

// File: rtl/spi_slave_regif_sync.sv
// Synchronizer chain plus one delay flop; yields level and single-cycle edge pulses.
module spi_in_sync #(
    parameter int STAGES = 2
) (
    input  logic sclk,
    input  logic srst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              dly_q;

    // Shift the asynchronous pin through the chain, keep last level for edge detect
    always_ff @(posedge sclk or posedge srst) begin
        if (srst) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            dly_q  <= sync_q[STAGES-1];
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise = q & ~dly_q;
    assign fall = ~q & dly_q;

endmodule

// File: rtl/spi_slave_regif.sv
// SPI mode-0 slave: decodes {cmd, addr, data} frames into register write
// strobes or read requests, and shifts read data back out on MISO.
module spi_slave_regif
    import spi_slave_pkg::*;
#(
    parameter logic [7:0] CMD_WR      = CMD_WR_DEF,
    parameter logic [7:0] CMD_RD      = CMD_RD_DEF,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       sclk,
    input  logic       srst,
    input  logic       SPI_SCLK,
    input  logic       SPI_CSN,
    input  logic       SPI_MOSI,
    output logic       SPI_MISO,
    output logic       SPI_MISO_OE,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       rd_req,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       frame_done,
    output logic       frame_err
);

    // A single-flop chain is metastability-unsafe; clamp rather than fail
    localparam int SYNC_N = (SYNC_STAGES < SYNC_MIN) ? SYNC_MIN : SYNC_STAGES;

    // Lane 0 = SCLK, 1 = CSN, 2 = MOSI
    logic [2:0] pin_lvl, pin_rise, pin_fall;

    spi_in_sync #(.STAGES(SYNC_N)) u_sync [2:0] (
        .sclk (sclk),
        .srst (srst),
        .d    ({SPI_MOSI, SPI_CSN, SPI_SCLK}),
        .q    (pin_lvl),
        .rise (pin_rise),
        .fall (pin_fall)
    );

    logic sck_rise, sck_fall, csn_rise, csn_fall, mosi;
    assign sck_rise = pin_rise[0];
    assign sck_fall = pin_fall[0];
    assign csn_rise = pin_rise[1];
    assign csn_fall = pin_fall[1];
    assign mosi     = pin_lvl[2];

    logic unused_pins;
    assign unused_pins = ^{pin_lvl[1:0], pin_rise[2], pin_fall[2]};

    state_t     state;
    logic [2:0] bit_cnt;
    logic [7:0] shreg_in, shreg_out, addr;
    logic       is_rd;     // latched read/write mode of the current frame
    logic       valid;     // frame reached its last byte with a known command
    logic       wr_pend;   // write strobe due next cycle
    logic       rd_pend;   // read request due next cycle
    logic       rd_load;   // rd_data is valid this cycle
    logic       miso_oe;

    logic       abort, last_bit;
    logic [7:0] shin_nxt;

    assign abort    = csn_rise && in_frame(state);
    assign last_bit = sck_rise && (bit_cnt == 3'd7);
    assign shin_nxt = {shreg_in[6:0], mosi};

    assign SPI_MISO    = miso_oe & shreg_out[7];
    assign SPI_MISO_OE = miso_oe;

    // Bit position within the current byte; restarts with every frame
    always_ff @(posedge sclk or posedge srst) begin
        if (srst)
            bit_cnt <= 3'd0;
        else if (csn_fall)
            bit_cnt <= 3'd0;
        else if (sck_rise && state != ST_IDLE)
            bit_cnt <= bit_cnt + 3'd1;
    end

    // Frame FSM with registered strobes and MISO shifter
    always_ff @(posedge sclk or posedge srst) begin
        if (srst) begin
            state      <= ST_IDLE;
            shreg_in   <= '0;
            shreg_out  <= '0;
            addr       <= '0;
            is_rd      <= 1'b0;
            valid      <= 1'b0;
            wr_pend    <= 1'b0;
            rd_pend    <= 1'b0;
            rd_load    <= 1'b0;
            miso_oe    <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            rd_req     <= 1'b0;
            rd_addr    <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            rd_req     <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            wr_pend    <= 1'b0;
            rd_pend    <= 1'b0;
            rd_load    <= rd_req;

            // A write is committed once its last bit is in, whatever CSN does next
            if (wr_pend) begin
                wr_en   <= 1'b1;
                wr_addr <= addr;
                wr_data <= shreg_in;
            end
            if (rd_pend && !abort) begin
                rd_req  <= 1'b1;
                rd_addr <= addr;
            end

            if (abort) begin
                frame_err <= 1'b1;
                miso_oe   <= 1'b0;
                shreg_out <= '0;
                state     <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (csn_fall) begin
                            valid <= 1'b0;
                            state <= ST_CMD;
                        end
                    end
                    ST_CMD: begin
                        if (sck_rise) shreg_in <= shin_nxt;
                        if (last_bit) begin
                            if (shin_nxt == CMD_WR) begin
                                is_rd <= 1'b0;
                                state <= ST_ADDR;
                            end else if (shin_nxt == CMD_RD) begin
                                is_rd <= 1'b1;
                                state <= ST_ADDR;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= ST_WAIT_CSN;
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (sck_rise) shreg_in <= shin_nxt;
                        if (last_bit) begin
                            addr <= shin_nxt;
                            if (is_rd) begin
                                rd_pend <= 1'b1;
                                miso_oe <= 1'b1;
                                state   <= ST_RDATA;
                            end else begin
                                state   <= ST_WDATA;
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (sck_rise) shreg_in <= shin_nxt;
                        if (last_bit) begin
                            wr_pend <= 1'b1;
                            valid   <= 1'b1;
                            state   <= ST_WAIT_CSN;
                        end
                    end
                    ST_RDATA: begin
                        // The fall right after the last address bit (bit_cnt==0)
                        // is skipped so bit 7 is held for the first data rise
                        if (rd_load)
                            shreg_out <= rd_data;
                        else if (sck_fall && bit_cnt != 3'd0)
                            shreg_out <= {shreg_out[6:0], 1'b0};
                        if (last_bit) begin
                            miso_oe   <= 1'b0;
                            shreg_out <= '0;
                            valid     <= 1'b1;
                            state     <= ST_WAIT_CSN;
                        end
                    end
                    ST_WAIT_CSN: begin
                        if (csn_fall) begin
                            valid <= 1'b0;
                            state <= ST_CMD;
                        end else if (csn_rise) begin
                            frame_done <= valid;
                            state      <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_regif.sv
// Directed plus randomized frames driven by a bit-level SPI master model;
// outcomes are predicted from a simple register-bank reference.
module tb_spi_slave_regif;
    import spi_slave_pkg::*;

    logic       sclk = 1'b0;
    logic       srst;
    logic       SPI_SCLK, SPI_CSN, SPI_MOSI;
    logic       SPI_MISO, SPI_MISO_OE;
    logic       wr_en, rd_req, frame_done, frame_err;
    logic [7:0] wr_addr, wr_data, rd_addr;
    logic [7:0] rd_data = '0;

    int n_chk  = 0;
    int n_fail = 0;

    spi_slave_regif dut (
        .sclk        (sclk),
        .srst        (srst),
        .SPI_SCLK    (SPI_SCLK),
        .SPI_CSN     (SPI_CSN),
        .SPI_MOSI    (SPI_MOSI),
        .SPI_MISO    (SPI_MISO),
        .SPI_MISO_OE (SPI_MISO_OE),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .frame_done  (frame_done),
        .frame_err   (frame_err)
    );

    always #5 sclk = ~sclk;

    // Unwritten registers read back as a fixed function of their address
    function automatic logic [7:0] dflt(input logic [7:0] a);
        return a ^ 8'hB5;
    endfunction

    // Register bank behind the slave: answers rd_req one cycle later, garbage otherwise
    logic [7:0]   bank [256];
    logic [255:0] bank_vld = '0;
    always @(posedge sclk) begin
        if (wr_en) begin
            bank[wr_addr]     <= wr_data;
            bank_vld[wr_addr] <= 1'b1;
        end
        rd_data <= rd_req ? (bank_vld[rd_addr] ? bank[rd_addr] : dflt(rd_addr)) : 8'($urandom);
    end

    // Event counters and values captured at each strobe
    int n_wr = 0, n_rd = 0, n_done = 0, n_err = 0, n_miso = 0;
    logic [7:0] m_wa = '0, m_wd = '0, m_ra = '0;
    always @(posedge sclk) begin
        if (wr_en) begin
            n_wr <= n_wr + 1;
            m_wa <= wr_addr;
            m_wd <= wr_data;
        end
        if (rd_req) begin
            n_rd <= n_rd + 1;
            m_ra <= rd_addr;
        end
        if (frame_done) n_done <= n_done + 1;
        if (frame_err)  n_err  <= n_err + 1;
        if (SPI_MISO && !SPI_MISO_OE) n_miso <= n_miso + 1;
    end

    logic [7:0] ref_mem [256];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Mode-0 master: MOSI changes while SCLK low, MISO sampled at each rise
    task automatic spi_xfer(input logic [23:0] fr, input int nbits, input int hp,
                            input bit is_rd, input bit raise, input int gap,
                            output logic [7:0] cap);
        cap = '0;
        @(negedge sclk);
        SPI_CSN = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            SPI_MOSI = fr[23-i];
            repeat (hp) @(negedge sclk);
            SPI_SCLK = 1'b1;
            if (i >= 16) cap = {cap[6:0], SPI_MISO};
            chk("miso_oe", SPI_MISO_OE, is_rd && i >= 16);
            if (!(is_rd && i >= 16)) chk("miso_idle", SPI_MISO, 1'b0);
            repeat (hp) @(negedge sclk);
            SPI_SCLK = 1'b0;
        end
        if (raise) begin
            repeat (hp) @(negedge sclk);
            SPI_CSN  = 1'b1;
            SPI_MOSI = 1'b0;
            repeat (gap) @(negedge sclk);
        end
    endtask

    // One full frame checked against the reference model
    task automatic run_frame(input logic [7:0] cmd, input logic [7:0] a, input logic [7:0] d,
                             input int hp, input int gap);
        int w0, r0, dn0, e0, m0;
        logic [7:0] cap;
        bit is_wr, is_rd;
        is_wr = (cmd == CMD_WR_DEF);
        is_rd = (cmd == CMD_RD_DEF);
        w0 = n_wr; r0 = n_rd; dn0 = n_done; e0 = n_err; m0 = n_miso;
        spi_xfer({cmd, a, d}, 24, hp, is_rd, 1'b1, gap, cap);
        repeat (6) @(negedge sclk);
        chk("wr_cnt",   n_wr - w0,    is_wr);
        chk("rd_cnt",   n_rd - r0,    is_rd);
        chk("done_cnt", n_done - dn0, is_wr || is_rd);
        chk("err_cnt",  n_err - e0,   !(is_wr || is_rd));
        chk("miso_stray", n_miso - m0, 0);
        if (is_wr) begin
            chk("wr_addr", m_wa, a);
            chk("wr_data", m_wd, d);
            ref_mem[a] = d;
        end
        if (is_rd) begin
            chk("rd_addr", m_ra, a);
            chk("rd_byte", cap, ref_mem[a]);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_wr_en"},   wr_en,       1'b0);
        chk({tag, "_wr_addr"}, wr_addr,     8'h00);
        chk({tag, "_wr_data"}, wr_data,     8'h00);
        chk({tag, "_rd_req"},  rd_req,      1'b0);
        chk({tag, "_rd_addr"}, rd_addr,     8'h00);
        chk({tag, "_done"},    frame_done,  1'b0);
        chk({tag, "_err"},     frame_err,   1'b0);
        chk({tag, "_oe"},      SPI_MISO_OE, 1'b0);
        chk({tag, "_miso"},    SPI_MISO,    1'b0);
    endtask

    initial begin
        int w0, r0, dn0, e0;
        logic [7:0] cap, c, a, d;
        int hp, gap, kind;

        for (int i = 0; i < 256; i++) ref_mem[i] = dflt(8'(i));
        SPI_SCLK = 1'b0; SPI_CSN = 1'b1; SPI_MOSI = 1'b0; srst = 1'b1;
        repeat (3) @(negedge sclk);
        chk_outputs_zero("rst");
        srst = 1'b0;
        repeat (5) @(negedge sclk);

        // Write, read, bad command
        run_frame(8'h02, 8'h5A, 8'hC3, MIN_HALF_PERIOD, 4);
        run_frame(8'h03, 8'h10, 8'h00, MIN_HALF_PERIOD, 4);
        chk("rd_A5", m_ra == 8'h10 ? ref_mem[8'h10] : 8'h00, 8'hA5);
        run_frame(8'h7E, 8'h01, 8'hFF, MIN_HALF_PERIOD, 4);

        // Abort after 20 rises, then a clean write
        w0 = n_wr; r0 = n_rd; dn0 = n_done; e0 = n_err;
        spi_xfer({8'h02, 8'h01, 8'h77}, 20, MIN_HALF_PERIOD, 1'b0, 1'b1, 4, cap);
        repeat (6) @(negedge sclk);
        chk("abort_err",  n_err - e0,   1);
        chk("abort_wr",   n_wr - w0,    0);
        chk("abort_rd",   n_rd - r0,    0);
        chk("abort_done", n_done - dn0, 0);
        run_frame(8'h02, 8'h01, 8'h33, MIN_HALF_PERIOD, 4);

        // Async reset mid-address byte
        w0 = n_wr; r0 = n_rd; dn0 = n_done; e0 = n_err;
        spi_xfer({8'h02, 8'h44, 8'h99}, 12, MIN_HALF_PERIOD, 1'b0, 1'b0, 0, cap);
        srst = 1'b1;
        #1;
        chk_outputs_zero("arst");
        SPI_CSN = 1'b1;
        repeat (4) @(negedge sclk);
        srst = 1'b0;
        repeat (10) @(negedge sclk);
        chk("arst_wr",   n_wr - w0,    0);
        chk("arst_rd",   n_rd - r0,    0);
        chk("arst_done", n_done - dn0, 0);
        chk("arst_err",  n_err - e0,   0);
        run_frame(8'h02, 8'hFF, 8'h00, MIN_HALF_PERIOD, 4);

        // Back-to-back read then write with a short CSN-high gap
        w0 = n_wr; r0 = n_rd; dn0 = n_done; e0 = n_err;
        spi_xfer({8'h03, 8'h5A, 8'h00}, 24, MIN_HALF_PERIOD, 1'b1, 1'b1, 4, cap);
        spi_xfer({8'h02, 8'h66, 8'hFF}, 24, MIN_HALF_PERIOD, 1'b0, 1'b1, 4, c);
        repeat (6) @(negedge sclk);
        chk("b2b_rd_cnt", n_rd - r0,    1);
        chk("b2b_wr_cnt", n_wr - w0,    1);
        chk("b2b_done",   n_done - dn0, 2);
        chk("b2b_err",    n_err - e0,   0);
        chk("b2b_rd_addr", m_ra, 8'h5A);
        chk("b2b_rd_byte", cap, ref_mem[8'h5A]);
        chk("b2b_wr_addr", m_wa, 8'h66);
        chk("b2b_wr_data", m_wd, 8'hFF);
        ref_mem[8'h66] = 8'hFF;

        // Randomized frames over a small address window so reads hit prior writes
        for (int n = 0; n < 14; n++) begin
            kind = $urandom_range(0, 2);
            a    = 8'h20 + 8'($urandom_range(0, 7));
            d    = 8'($urandom);
            hp   = $urandom_range(MIN_HALF_PERIOD, MIN_HALF_PERIOD + 2);
            gap  = $urandom_range(4, 10);
            if (kind == 0) c = CMD_WR_DEF;
            else if (kind == 1) c = CMD_RD_DEF;
            else begin
                c = 8'($urandom);
                while (c == CMD_WR_DEF || c == CMD_RD_DEF) c = 8'($urandom);
            end
            run_frame(c, a, d, hp, gap);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
